// File: rtl/mux_32to1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_32to1_rr
// Purpose  : Round-robin 32-to-1 gather mux with valid/ready handshakes and a
//            single registered output stage tagging each word with its lane.
//            Define MUX_32TO1_RR_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0  initial release
// ============================================================================
module mux_32to1_rr #(
  parameter int WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [31:0]           valid_i,
  input  logic [32*WIDTH-1:0]   data_i,
  output logic [31:0]           ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [4:0]            sel_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] grant;
  logic       any_req;
  logic       can_load;
  logic       accept;

`ifndef MUX_32TO1_RR_FIXED_PRIO_EN
  logic [4:0] ptr;
  logic [4:0] idx;
`endif

  assign any_req  = |valid_i;
  assign can_load = (state == EMPTY) || ready_i;
  // Reset is folded in so ready_o stays low for the whole reset window.
  assign accept   = rst_ni && en_i && can_load && any_req;

  // Scan downward so the last hit, i.e. the nearest lane at or above the
  // starting point, is the one that sticks.
  always_comb begin
    grant = '0;
`ifdef MUX_32TO1_RR_FIXED_PRIO_EN
    for (int i = 31; i >= 0; i--) begin
      if (valid_i[i]) grant = 5'(i);
    end
`else
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr + 5'(i);
      if (valid_i[idx]) grant = idx;
    end
`endif
  end

  assign ready_o = accept ? (32'd1 << grant) : 32'd0;
  assign valid_o = (state == FULL);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (accept) state_next = FULL;
               else if (ready_i) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_next;
  end

  // Payload only moves on an accept; a plain drain leaves it in place.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o <= '0;
      sel_o  <= '0;
`ifndef MUX_32TO1_RR_FIXED_PRIO_EN
      ptr    <= '0;
`endif
    end else if (accept) begin
      data_o <= data_i[int'(grant)*WIDTH +: WIDTH];
      sel_o  <= grant;
`ifndef MUX_32TO1_RR_FIXED_PRIO_EN
      ptr    <= grant + 5'd1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_32to1_rr.sv
`default_nettype none
// Testbench for mux_32to1_rr: directed scenarios plus random traffic, checked
// through a scoreboard queue fed by a spec-level reference model.
module tb_mux_32to1_rr;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      valid_in = '0;
  logic [32*W-1:0]  data_in = '0;
  logic [31:0]      ready_out;
  logic [W-1:0]     data_out;
  logic [4:0]       sel_out;
  logic             valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]   sel;
    logic [W-1:0] data;
  } word_t;

  word_t sbq[$];
  int    ptr = 0;
  bit    full = 1'b0;

  mux_32to1_rr #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .valid_i (valid_in),
    .data_i  (data_in),
    .ready_o (ready_out),
    .data_o  (data_out),
    .sel_o   (sel_out),
    .valid_o (valid_out),
    .ready_i (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting lane at or after the pointer.
  function automatic int pick(input logic [31:0] v, input int p);
`ifdef MUX_32TO1_RR_FIXED_PRIO_EN
    for (int i = 0; i < 32; i++) if (v[i]) return i;
`else
    for (int i = 0; i < 32; i++) if (v[(p + i) % 32]) return (p + i) % 32;
`endif
    return -1;
  endfunction

  // One clock: inputs already driven; check ready_o mid-cycle, update model at the edge.
  task automatic step();
    int          k;
    bit          acc;
    logic [31:0] exp_ready;
    word_t       w;
    @(negedge clk);
    k   = pick(valid_in, ptr);
    acc = rst_n && en && (!full || out_ready) && (valid_in != 0);
    exp_ready = acc ? (32'd1 << k) : 32'd0;
    chk("ready_o", 64'(ready_out), 64'(exp_ready));
    w = '0;
    if (acc) begin
      w.sel  = 5'(k);
      w.data = data_in[k*W +: W];
    end
    @(posedge clk);
    if (!rst_n) begin
      sbq.delete();
      full = 1'b0;
      ptr  = 0;
    end else if (acc) begin
      sbq.push_back(w);
      full = 1'b1;
      ptr  = (k + 1) % 32;
    end else if (out_ready) begin
      full = 1'b0;
    end
    #1;
    if (!rst_n) begin
      chk("reset valid_o", 64'(valid_out), 64'd0);
      chk("reset sel_o", 64'(sel_out), 64'd0);
      chk("reset data_o", 64'(data_out), 64'd0);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 32; i++) data_in[i*W +: W] = W'($urandom);
  endtask

  // Monitor: the word on the output must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid_o", 64'(valid_out), 64'(sbq.size() != 0));
        if (sbq.size() != 0) begin
          chk("sel_o", 64'(sel_out), 64'(sbq[0].sel));
          chk("data_o", 64'(data_out), 64'(sbq[0].data));
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int rr_exp[4];
`ifdef MUX_32TO1_RR_FIXED_PRIO_EN
    rr_exp = '{1, 1, 1, 1};
`else
    rr_exp = '{1, 14, 31, 1};
`endif
    rand_data();
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; valid_in = 32'hFFFF_FFFF;
    repeat (2) step();
    rst_n = 1'b1;

    // Round-robin over three lanes from a freshly reset pointer.
    valid_in = 32'h8000_4002;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr sequence", 64'(sel_out), 64'(rr_exp[i]));
    end
    valid_in = '0; step();

    // Single lane 6.
    data_in = '0; data_in[6*W +: W] = W'(1);
    valid_in = 32'h0000_0040; step();
    valid_in = '0; step();

    // Backpressure holding lane 3.
    rand_data();
    valid_in = 32'h0000_0008; step();
    out_ready = 1'b0; valid_in = 32'hFFFF_FFFF;
    repeat (4) step();
    out_ready = 1'b1; step();

    // Enable off drains the held word without new grants.
    en = 1'b0; repeat (3) step();
    en = 1'b1; valid_in = '0; step();

    // Pointer wrap after lane 31.
    valid_in = 32'h8000_0000; step();
    valid_in = 32'h8000_0001; repeat (2) step();
    valid_in = '0; step();

    // Reset while a word is held.
    out_ready = 1'b0; valid_in = 32'h0000_0100; step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; out_ready = 1'b1; valid_in = '0; step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rand_data();
      rst_n     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       valid_in = '0;
        1:       valid_in = 32'd1 << $urandom_range(0, 31);
        2:       valid_in = $urandom;
        default: valid_in = $urandom & $urandom & $urandom;
      endcase
      step();
    end

    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1; valid_in = '0;
    repeat (3) step();
    chk("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mux_32to1_rr.md
# mux_32to1_rr

Round-robin 32-to-1 multiplexer that collects traffic from 32 independent source lanes onto one output channel, tagging each word with its 5-bit source index. It is the gather side of the `demux_1to32` scatter path: the demux fans one stream out by select, and this block fans 32 streams back in and regenerates the select. It uses valid/ready handshakes with a single registered output stage, sustaining one transfer per cycle.

## Interface
- `WIDTH`, default 1: data width per lane.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `en_i`  in  1  global enable; when low, no new lane is accepted.
- `valid_i`  in  32  per-lane request; bit k means lane k has data.
- `data_i`  in  32*WIDTH  lane k data at `[k*WIDTH +: WIDTH]`.
- `ready_o`  out  32  one-hot accept; bit k high means lane k is consumed this cycle.
- `data_o`  out  WIDTH  registered data of the granted lane.
- `sel_o`  out  5  registered index of the granted lane.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  downstream accepts the output word.

## Operation
- Output stage states:
  - EMPTY: `valid_o`=0.
  - FULL: `valid_o`=1.
- The stage can load a new word when the block is in EMPTY, or in FULL with `ready_i`=1.
- Accept condition: `rst_ni`=1, `en_i`=1, the stage can load, and `valid_i`≠0.
- Arbitration:
  - Internal 5-bit priority pointer `ptr`.
  - The granted lane k is the first set bit of `valid_i` searching upward from `ptr`, wrapping 31→0.
- On an accept:
  - `ready_o[k]`=1 combinationally in the same cycle; all other `ready_o` bits are 0.
  - At the clock edge: `data_o`←lane k data, `sel_o`←k, `valid_o`←1, `ptr`←(k+1) mod 32.
- No accept and `ready_i`=1 in FULL: `valid_o`←0. `data_o` and `sel_o` hold their last values.
- No accept and `ready_i`=0 in FULL: all outputs hold.
- `en_i`=0:
  - `ready_o`=0.
  - A word already in FULL still drains normally.
  - `ptr` is unchanged.
- `ready_o` never depends on `ready_i` when in EMPTY.
- A lane whose `valid_i` drops before being granted is simply skipped; no state is kept per lane.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `sel_o`=0, `ptr`=0, `ready_o`=0.
  - `ready_o` is forced to 0 while `rst_ni`=0.
- Latency: 1 cycle from the `ready_o[k]` pulse to `valid_o`=1 with `sel_o`=k.
- Throughput: 1 word/cycle when `ready_i` is held high and requests are present.
- Simultaneous drain and load in FULL (`ready_i`=1 plus an accept): the new word replaces the old word at the edge and `valid_o` stays 1.
- Reset asserted mid-transfer: the output word is discarded at the next edge and `ptr` returns to 0.
- The `ptr` wrap after granting lane 31 is 0.

## Configuration
- Macro `MUX_32TO1_RR_FIXED_PRIO_EN`.
  - Defined: fixed priority. The lowest-indexed set bit of `valid_i` always wins, and `ptr` is not implemented.
  - Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- Reset: `rst_ni`=0 for 2 cycles with `valid_i`=32'hFFFF_FFFF → `ready_o`=0, `valid_o`=0, `sel_o`=0, `data_o`=0.
- Single lane: `valid_i`=32'h0000_0040, lane 6 data=1, `ready_i`=1 → `ready_o`=32'h0000_0040 that cycle; next cycle `valid_o`=1, `sel_o`=6, `data_o`=1.
- Round-robin: `valid_i`=32'h8000_4002 held, `ready_i`=1 → `sel_o` sequence 1, 14, 31, 1, one per cycle.
  - With `MUX_32TO1_RR_FIXED_PRIO_EN` defined → `sel_o` is 1 every cycle.
- Backpressure: in FULL with `sel_o`=3, hold `ready_i`=0 for 4 cycles → `valid_o`=1, `sel_o`=3 and `data_o` stable, `ready_o`=0. Raise `ready_i` → a new grant occurs that same cycle.
- Enable off: `en_i`=0, `valid_i`=32'hFFFF_FFFF, `ready_i`=1 → `ready_o`=0; `valid_o` falls 1 cycle after the held word drains.
- Wrap: after lane 31 is granted, `valid_i`=32'h8000_0001 → the next grant is lane 0, then lane 31.
